// File: rtl/branch_resolver.sv
// Pipeline-side client of the 2-bit branch predictor: requests and captures predictions,
// queues them in order until execute resolves them, and flags and flushes mispredicts.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_fetch_valid,
  output logic              br_fetch_ready,
  output logic              br_pred_valid,
  output logic              br_pred_taken,
  input  logic              br_exec_valid,
  input  logic              br_exec_taken,
  output logic              request,
  input  logic              prediction,
  output logic              result,
  output logic              taken,
  output logic              mispredict,
  output logic [CNT_W-1:0]  inflight,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred,
  output logic              underflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1'b1);
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return ptr + PTR_ONE;
    end
  endfunction

  logic [DEPTH-1:0]  fifo_r, fifo_nxt_s;
  logic [PTR_W-1:0]  head_r, head_nxt_s;
  logic [PTR_W-1:0]  tail_r, tail_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              pending_r, pending_nxt_s;
  logic              mispredict_r;
  logic [STAT_W-1:0] stat_branches_r, stat_branches_nxt_s;
  logic [STAT_W-1:0] stat_mispred_r, stat_mispred_nxt_s;
  logic              underflow_r, underflow_nxt_s;

  logic [CNT_W:0]    occupancy_s;
  logic              ready_s;
  logic              accept_s;
  logic              resolve_s;
  logic              head_pred_s;
  logic              mispred_s;

  // Handshake decode: a pending capture already owns a slot, so it counts against ready.
  always_comb begin
    occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, pending_r};
    ready_s     = (occupancy_s < DEPTH_EXT);
    accept_s    = br_fetch_valid & ready_s & rst_n;
    resolve_s   = br_exec_valid & (count_r != CNT_ZERO) & rst_n;
    head_pred_s = fifo_r[head_r];
    mispred_s   = resolve_s & (head_pred_s ^ br_exec_taken);
  end

  // FIFO, pending-capture and statistics next-state.
  always_comb begin
    fifo_nxt_s          = fifo_r;
    head_nxt_s          = head_r;
    tail_nxt_s          = tail_r;
    count_nxt_s         = count_r;
    pending_nxt_s       = pending_r;
    stat_branches_nxt_s = stat_branches_r;
    stat_mispred_nxt_s  = stat_mispred_r;
    underflow_nxt_s     = underflow_r;

    if (mispred_s) begin
      // Everything younger than the mispredicted head is wrong-path, including
      // the capture and any accept happening on this same edge.
      head_nxt_s    = PTR_ZERO;
      tail_nxt_s    = PTR_ZERO;
      count_nxt_s   = CNT_ZERO;
      pending_nxt_s = 1'b0;
    end else begin
      if (pending_r) begin
        fifo_nxt_s[tail_r] = prediction;
        tail_nxt_s         = ptr_inc(tail_r);
      end else begin
        tail_nxt_s = tail_r;
      end
      if (resolve_s) begin
        head_nxt_s = ptr_inc(head_r);
      end else begin
        head_nxt_s = head_r;
      end
      count_nxt_s   = count_r + (pending_r ? CNT_ONE : CNT_ZERO)
                              - (resolve_s ? CNT_ONE : CNT_ZERO);
      pending_nxt_s = accept_s;
    end

    if (resolve_s && (stat_branches_r != STAT_MAX)) begin
      stat_branches_nxt_s = stat_branches_r + STAT_ONE;
    end else begin
      stat_branches_nxt_s = stat_branches_r;
    end

    if (mispred_s && (stat_mispred_r != STAT_MAX)) begin
      stat_mispred_nxt_s = stat_mispred_r + STAT_ONE;
    end else begin
      stat_mispred_nxt_s = stat_mispred_r;
    end

    if (br_exec_valid && (count_r == CNT_ZERO)) begin
      underflow_nxt_s = 1'b1;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  // State registers with synchronous active-low reset taking priority over every event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_r          <= {DEPTH{1'b0}};
      head_r          <= PTR_ZERO;
      tail_r          <= PTR_ZERO;
      count_r         <= CNT_ZERO;
      pending_r       <= 1'b0;
      mispredict_r    <= 1'b0;
      stat_branches_r <= STAT_ZERO;
      stat_mispred_r  <= STAT_ZERO;
      underflow_r     <= 1'b0;
    end else begin
      fifo_r          <= fifo_nxt_s;
      head_r          <= head_nxt_s;
      tail_r          <= tail_nxt_s;
      count_r         <= count_nxt_s;
      pending_r       <= pending_nxt_s;
      mispredict_r    <= mispred_s;
      stat_branches_r <= stat_branches_nxt_s;
      stat_mispred_r  <= stat_mispred_nxt_s;
      underflow_r     <= underflow_nxt_s;
    end
  end

  assign br_fetch_ready = ready_s;
  assign br_pred_valid  = pending_r;
  assign br_pred_taken  = prediction & pending_r;
  assign request        = accept_s;
  assign result         = resolve_s;
  assign taken          = br_exec_taken;
  assign mispredict     = mispredict_r;
  assign inflight       = count_r;
  assign stat_branches  = stat_branches_r;
  assign stat_mispred   = stat_mispred_r;
  assign underflow_err  = underflow_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a vector table for the main flow plus
// hand-written sequences for overlap/wrap, underflow, saturation and reset.
module tb_branch_resolver;

  logic clk = 1'b0;
  logic rst_n, fv, ev, et, pred;

  logic        rdy, pv, pt, req, res, tk, mp, uf;
  logic [2:0]  infl;
  logic [15:0] sb, sm;

  logic        rdy2, pv2, pt2, req2, res2, tk2, mp2, uf2;
  logic [2:0]  infl2;
  logic [1:0]  sb2, sm2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(4), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .br_fetch_valid(fv), .br_fetch_ready(rdy),
    .br_pred_valid(pv), .br_pred_taken(pt), .br_exec_valid(ev), .br_exec_taken(et),
    .request(req), .prediction(pred), .result(res), .taken(tk), .mispredict(mp),
    .inflight(infl), .stat_branches(sb), .stat_mispred(sm), .underflow_err(uf)
  );

  branch_resolver #(.DEPTH(4), .STAT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_fetch_valid(fv), .br_fetch_ready(rdy2),
    .br_pred_valid(pv2), .br_pred_taken(pt2), .br_exec_valid(ev), .br_exec_taken(et),
    .request(req2), .prediction(pred), .result(res2), .taken(tk2), .mispredict(mp2),
    .inflight(infl2), .stat_branches(sb2), .stat_mispred(sm2), .underflow_err(uf2)
  );

  typedef struct packed {
    logic       fv, ev, et, pr;
    logic       rdy, req, pv, pt, res, mp;
    logic [2:0] infl;
    logic [3:0] sb, sm;
    logic       uf;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic e, input logic t, input logic p);
    fv = f; ev = e; et = t; pred = p;
  endtask

  initial begin
    logic [7:0] bits;

    //                fv    ev    et    pr  | rdy   req   pv    pt    res   mp    infl  sb    sm    uf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'd0, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 4'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd1, 4'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd1, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd1, 4'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'd1, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'd1, 4'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2, 4'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd3, 4'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 4'd1, 1'b0};

    // Reset with traffic on the inputs.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step(); step(); step();
    chk("rst_ready", 0, rdy, 1'b1);
    chk("rst_request", 0, req, 1'b0);
    chk("rst_pred_valid", 0, pv, 1'b0);
    chk("rst_pred_taken", 0, pt, 1'b0);
    chk("rst_result", 0, res, 1'b0);
    chk("rst_mispredict", 0, mp, 1'b0);
    chk("rst_inflight", 0, infl, 3'd0);
    chk("rst_stat_branches", 0, sb, 16'd0);
    chk("rst_stat_mispred", 0, sm, 16'd0);
    chk("rst_underflow", 0, uf, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Single branch, fill to DEPTH, correct resolve, then mispredict flush.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].fv, vecs[i].ev, vecs[i].et, vecs[i].pr);
      #3;
      chk("ready", i, rdy, vecs[i].rdy);
      chk("request", i, req, vecs[i].req);
      chk("pred_valid", i, pv, vecs[i].pv);
      chk("pred_taken", i, pt, vecs[i].pt);
      chk("result", i, res, vecs[i].res);
      chk("mispredict", i, mp, vecs[i].mp);
      chk("inflight", i, infl, {29'd0, vecs[i].infl});
      chk("stat_branches", i, sb, {12'd0, vecs[i].sb});
      chk("stat_mispred", i, sm, {12'd0, vecs[i].sm});
      chk("underflow", i, uf, vecs[i].uf);
      if (vecs[i].ev) begin
        chk("taken", i, tk, vecs[i].et);
      end else begin
        chk("taken_idle", i, tk, 1'b0);
      end
      step();
    end
    chk("sat_branches_3", 0, sb2, 2'd3);
    chk("sat_mispred_1", 0, sm2, 2'd1);

    // Capture and resolve on the same edge; 8 branches wrap the 4-entry FIFO.
    bits = 8'b1001_1010;
    for (int k = 0; k < 10; k++) begin
      drive((k < 8) ? 1'b1 : 1'b0,
            (k >= 2) ? 1'b1 : 1'b0,
            (k >= 2) ? bits[k-2] : 1'b0,
            (k >= 1 && k <= 8) ? bits[k-1] : 1'b0);
      #3;
      if (k < 8) chk("ovl_ready", k, rdy, 1'b1);
      if (k >= 2) begin
        chk("ovl_result", k, res, 1'b1);
        chk("ovl_inflight", k, infl, 3'd1);
      end
      if (k >= 3) chk("ovl_no_mispredict", k, mp, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("ovl_end_mispredict", 0, mp, 1'b0);
    chk("ovl_end_inflight", 0, infl, 3'd0);
    chk("ovl_end_branches", 0, sb, 16'd11);
    chk("ovl_end_mispred", 0, sm, 16'd1);
    step();

    // Underflow: resolve with nothing in flight.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("uf_result", 0, res, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("uf_sticky", 0, uf, 1'b1);
    chk("uf_branches", 0, sb, 16'd11);
    chk("uf_inflight", 0, infl, 3'd0);
    chk("sat_branches_hold", 0, sb2, 2'd3);
    step();
    #3;
    chk("uf_sticky_hold", 0, uf, 1'b1);

    // Reset lands on the edge that would capture a prediction.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    #3;
    chk("rmc_request_in_reset", 0, req, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    chk("rmc_pred_valid", 0, pv, 1'b0);
    chk("rmc_underflow", 0, uf, 1'b0);
    chk("rmc_branches", 0, sb, 16'd0);
    step();
    #3;
    chk("rmc_inflight", 0, infl, 3'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
